// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg
//   Shared types and constants for the UART register-access responder.
//   Holds the responder state encoding, the CMD byte field positions,
//   the write-acknowledge byte and a helper that extracts the burst length.
//   Optional feature macro: UART_REG_RESP_ACK_EN adds the S_ACK state.
package uart_reg_pkg;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_LEN_MSB = 3;
  localparam int CMD_LEN_LSB = 0;

  localparam logic [7:0] ACK_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_WDATA_H,
    S_WDATA_L,
    S_RD_BUS,
    S_RD_WAIT,
    S_TX_H,
    S_TX_L
`ifdef UART_REG_RESP_ACK_EN
    ,
    S_ACK
`endif
  } state_t;

  // Burst length minus one, taken from the low nibble of the CMD byte.
  function automatic logic [3:0] cmd_len(input logic [7:0] cmd);
    return cmd[CMD_LEN_MSB:CMD_LEN_LSB];
  endfunction

endpackage

// File: rtl/uart_reg_gap_timer.sv
// uart_reg_gap_timer
//   Inter-byte silence timer. Counts clock cycles while enabled and raises
//   expired once the count reaches TIMEOUT.
// Ports
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  restart the count (a byte arrived)
//   enable   in  count only while a frame is partially received
//   expired  out silence has lasted TIMEOUT cycles
module uart_reg_gap_timer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // Holding the count at zero while disabled means every frame starts from
  // a fresh gap, regardless of how the previous frame ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clear || !enable) begin
      count <= 16'd0;
    end else if (!expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == TIMEOUT);

endmodule

// File: rtl/uart_reg_responder.sv
// uart_reg_responder
//   Device side of the UART register-access protocol. Parses CMD, ADDR_H,
//   ADDR_L (+ data pairs for writes) from the RX byte stream, performs
//   single/burst register writes and reads, and returns read data on TX.
//   Optional macro UART_REG_RESP_ACK_EN: send 8'hA5 after each write frame.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_valid, rx_data     received byte strobe and value
//   tx_valid, tx_data,
//   tx_ready              outgoing byte, held until accepted
//   bus_addr, bus_wr,
//   bus_wdata, bus_rd,
//   bus_rdata             register bus (read data valid cycle after bus_rd)
//   busy                  high whenever a frame is in progress
module uart_reg_responder
  import uart_reg_pkg::*;
#(
  parameter logic [3:0]  BASEADDR = 4'h0,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [11:0] bus_addr,
  output logic        bus_wr,
  output logic [15:0] bus_wdata,
  output logic        bus_rd,
  input  logic [15:0] bus_rdata,
  output logic        busy
);

`ifdef UART_REG_RESP_ACK_EN
  localparam state_t WR_DONE = S_ACK;
`else
  localparam state_t WR_DONE = S_IDLE;
`endif

  state_t      state, state_next;
  logic        is_write;
  logic        addr_match;
  logic [3:0]  len;
  logic [3:0]  beat;
  logic [7:0]  data_h;
  logic [15:0] rd_data;
  logic        last_beat;
  logic        gap_enable;
  logic        gap_expired;

  assign last_beat  = (beat == len);
  assign gap_enable = (state == S_ADDR_H) || (state == S_ADDR_L) ||
                      (state == S_WDATA_H) || (state == S_WDATA_L);

  uart_reg_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid),
    .enable  (gap_enable),
    .expired (gap_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // A received byte takes priority over an expiring gap in the same cycle.
  // Mismatched reads drop straight back to IDLE after ADDR_L; mismatched
  // writes still walk the data beats so the payload bytes are consumed.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    bus_rd     = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rx_valid) state_next = S_ADDR_H;
      end
      S_ADDR_H: begin
        if (rx_valid)         state_next = S_ADDR_L;
        else if (gap_expired) state_next = S_IDLE;
      end
      S_ADDR_L: begin
        if (rx_valid) begin
          if (is_write)        state_next = S_WDATA_H;
          else if (addr_match) state_next = S_RD_BUS;
          else                 state_next = S_IDLE;
        end else if (gap_expired) begin
          state_next = S_IDLE;
        end
      end
      S_WDATA_H: begin
        if (rx_valid)         state_next = S_WDATA_L;
        else if (gap_expired) state_next = S_IDLE;
      end
      S_WDATA_L: begin
        if (rx_valid)         state_next = last_beat ? WR_DONE : S_WDATA_H;
        else if (gap_expired) state_next = S_IDLE;
      end
      S_RD_BUS: begin
        bus_rd     = 1'b1;
        state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        state_next = S_TX_H;
      end
      S_TX_H: begin
        tx_valid = 1'b1;
        tx_data  = rd_data[15:8];
        if (tx_ready) state_next = S_TX_L;
      end
      S_TX_L: begin
        tx_valid = 1'b1;
        tx_data  = rd_data[7:0];
        if (tx_ready) state_next = last_beat ? S_IDLE : S_RD_BUS;
      end
`ifdef UART_REG_RESP_ACK_EN
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Frame fields and bus datapath. The write strobe is registered so it
  // lands the cycle after DATA_L; the address steps on the cycle after
  // each write strobe, and after each completed read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write   <= 1'b0;
      addr_match <= 1'b0;
      len        <= 4'd0;
      beat       <= 4'd0;
      data_h     <= 8'h00;
      rd_data    <= 16'h0000;
      bus_addr   <= 12'h000;
      bus_wr     <= 1'b0;
      bus_wdata  <= 16'h0000;
    end else begin
      bus_wr <= 1'b0;
      if (bus_wr) bus_addr <= bus_addr + 12'd1;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            is_write <= rx_data[CMD_WR_BIT];
            len      <= cmd_len(rx_data);
            beat     <= 4'd0;
          end
        end
        S_ADDR_H: begin
          if (rx_valid) begin
            addr_match     <= (rx_data[7:4] == BASEADDR);
            bus_addr[11:8] <= rx_data[3:0];
          end
        end
        S_ADDR_L: begin
          if (rx_valid) bus_addr[7:0] <= rx_data;
        end
        S_WDATA_H: begin
          if (rx_valid) data_h <= rx_data;
        end
        S_WDATA_L: begin
          if (rx_valid) begin
            bus_wr    <= addr_match;
            bus_wdata <= {data_h, rx_data};
            beat      <= beat + 4'd1;
          end
        end
        S_RD_WAIT: begin
          rd_data <= bus_rdata;
        end
        S_TX_L: begin
          if (tx_ready && !last_beat) begin
            bus_addr <= bus_addr + 12'd1;
            beat     <= beat + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder
//   Directed bench for uart_reg_responder (BASEADDR=2, short TIMEOUT).
//   A small register memory answers the bus, monitors log bus accesses and
//   accepted TX bytes, and directed frames are checked against constants.
//   Building with UART_REG_RESP_ACK_EN makes write frames expect an 8'hA5.
module tb_uart_reg_responder;

  localparam logic [3:0]  BASE    = 4'h2;
  localparam logic [15:0] TIMEOUT = 16'd100;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [11:0] bus_addr;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic        bus_rd;
  logic [15:0] bus_rdata;
  logic        busy;

  int checkCount  = 0;
  int errorCount  = 0;
  int stallCycles = 0;
  int waitCnt     = 0;
  logic [7:0] heldByte;

  logic [7:0]  txQ[$];
  logic [27:0] wrQ[$];
  logic [11:0] rdQ[$];
  logic [15:0] mem[0:4095];

  uart_reg_responder #(.BASEADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Register memory: read data appears the cycle after bus_rd.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    bus_rdata = 16'h0000;
  end

  always @(posedge clk) begin
    if (bus_wr) mem[bus_addr] <= bus_wdata;
    if (bus_rd) bus_rdata <= mem[bus_addr];
  end

  // Bus access log.
  always @(negedge clk) begin
    if (rst_n && bus_wr) wrQ.push_back({bus_addr, bus_wdata});
    if (rst_n && bus_rd) rdQ.push_back(bus_addr);
  end

  // TX sink: holds tx_ready low for stallCycles cycles per byte and checks
  // that the byte stays put while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ready = 1'b0;
      waitCnt  = 0;
    end else if (tx_valid) begin
      if (waitCnt == 0) heldByte = tx_data;
      if (waitCnt >= stallCycles) begin
        tx_ready = 1'b1;
        if (stallCycles > 0) checkOutput("tx_hold", 32'(tx_data), 32'(heldByte));
        txQ.push_back(tx_data);
        waitCnt = 0;
      end else begin
        tx_ready = 1'b0;
        waitCnt++;
      end
    end else begin
      tx_ready = 1'b0;
      waitCnt  = 0;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 500; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput(tag, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clearLogs();
    txQ.delete();
    wrQ.delete();
    rdQ.delete();
  endtask

  task automatic checkAck(input string tag);
`ifdef UART_REG_RESP_ACK_EN
    checkOutput({tag, "_n"}, 32'(txQ.size()), 32'd1);
    checkOutput({tag, "_b"}, 32'(txQ[0]), 32'hA5);
`else
    checkOutput({tag, "_n"}, 32'(txQ.size()), 32'd0);
`endif
  endtask

  function automatic logic [15:0] burstWord(input int i);
    return (i < 15) ? 16'((i + 1) * 16'h1111) : 16'hABCD;
  endfunction

  initial begin
    logic [15:0] d;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_outs",
                {11'd0, busy, tx_valid, bus_wr, bus_rd, bus_addr, tx_data},
                32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write 0x8888 to 0x008.
    clearLogs();
    applyStimulus(8'h80); applyStimulus(8'h20); applyStimulus(8'h08);
    applyStimulus(8'h88); applyStimulus(8'h88);
    waitIdle("w1_idle");
    checkOutput("w1_n", 32'(wrQ.size()), 32'd1);
    checkOutput("w1_wr", 32'(wrQ[0]), {4'd0, 12'h008, 16'h8888});
    checkAck("w1_ack");

    // Single read of 0x008 with 3-cycle TX stalls.
    clearLogs();
    stallCycles = 3;
    applyStimulus(8'h00); applyStimulus(8'h20); applyStimulus(8'h08);
    waitIdle("r1_idle");
    stallCycles = 0;
    checkOutput("r1_rdn", 32'(rdQ.size()), 32'd1);
    checkOutput("r1_rda", 32'(rdQ[0]), 32'h008);
    checkOutput("r1_txn", 32'(txQ.size()), 32'd2);
    checkOutput("r1_tx0", 32'(txQ[0]), 32'h88);
    checkOutput("r1_tx1", 32'(txQ[1]), 32'h88);

    // 16-beat burst write from 0x001.
    clearLogs();
    applyStimulus(8'h8F); applyStimulus(8'h20); applyStimulus(8'h01);
    for (int i = 0; i < 16; i++) begin
      d = burstWord(i);
      applyStimulus(d[15:8]);
      applyStimulus(d[7:0]);
    end
    waitIdle("bw_idle");
    checkOutput("bw_n", 32'(wrQ.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("bw_%0d", i), 32'(wrQ[i]),
                  {4'd0, 12'(12'h001 + i), burstWord(i)});
    checkAck("bw_ack");

    // 16-beat burst read back.
    clearLogs();
    applyStimulus(8'h0F); applyStimulus(8'h20); applyStimulus(8'h01);
    waitIdle("br_idle");
    checkOutput("br_rdn", 32'(rdQ.size()), 32'd16);
    checkOutput("br_last", 32'(rdQ[15]), 32'h010);
    checkOutput("br_txn", 32'(txQ.size()), 32'd32);
    for (int i = 0; i < 16; i++) begin
      d = burstWord(i);
      checkOutput($sformatf("br_h%0d", i), 32'(txQ[2*i]), 32'(d[15:8]));
      checkOutput($sformatf("br_l%0d", i), 32'(txQ[2*i+1]), 32'(d[7:0]));
    end

    // Address wrap 0xFFF -> 0x000 across a 2-beat write.
    clearLogs();
    applyStimulus(8'h81); applyStimulus(8'h2F); applyStimulus(8'hFF);
    applyStimulus(8'h01); applyStimulus(8'h02);
    applyStimulus(8'h03); applyStimulus(8'h04);
    waitIdle("wrap_idle");
    checkOutput("wrap_n", 32'(wrQ.size()), 32'd2);
    checkOutput("wrap_0", 32'(wrQ[0]), {4'd0, 12'hFFF, 16'h0102});
    checkOutput("wrap_1", 32'(wrQ[1]), {4'd0, 12'h000, 16'h0304});
    checkAck("wrap_ack");

    // Base mismatch write and read: nothing on the bus, no read data.
    clearLogs();
    applyStimulus(8'h80); applyStimulus(8'h30); applyStimulus(8'h08);
    applyStimulus(8'h12); applyStimulus(8'h34);
    waitIdle("mw_idle");
    checkOutput("mw_n", 32'(wrQ.size()), 32'd0);
    checkAck("mw_ack");
    clearLogs();
    applyStimulus(8'h00); applyStimulus(8'h30); applyStimulus(8'h08);
    waitIdle("mr_idle");
    checkOutput("mr_rdn", 32'(rdQ.size()), 32'd0);
    checkOutput("mr_txn", 32'(txQ.size()), 32'd0);

    // Valid frames after the mismatches.
    clearLogs();
    applyStimulus(8'h80); applyStimulus(8'h20); applyStimulus(8'h08);
    applyStimulus(8'h12); applyStimulus(8'h34);
    waitIdle("w2_idle");
    checkOutput("w2_wr", 32'(wrQ[0]), {4'd0, 12'h008, 16'h1234});
    checkAck("w2_ack");
    clearLogs();
    applyStimulus(8'h00); applyStimulus(8'h20); applyStimulus(8'h08);
    waitIdle("r2_idle");
    checkOutput("r2_tx0", 32'(txQ[0]), 32'h12);
    checkOutput("r2_tx1", 32'(txQ[1]), 32'h34);

    // Inter-byte timeout after DATA_H.
    clearLogs();
    applyStimulus(8'h80); applyStimulus(8'h20); applyStimulus(8'h08);
    applyStimulus(8'h12);
    repeat (int'(TIMEOUT) - 8) @(negedge clk);
    checkOutput("to_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("to_idle", 32'(busy), 32'd0);
    checkOutput("to_wrn", 32'(wrQ.size()), 32'd0);
    checkOutput("to_txn", 32'(txQ.size()), 32'd0);
    applyStimulus(8'h80); applyStimulus(8'h20); applyStimulus(8'h09);
    applyStimulus(8'h56); applyStimulus(8'h78);
    waitIdle("w3_idle");
    checkOutput("w3_wr", 32'(wrQ[0]), {4'd0, 12'h009, 16'h5678});
    checkAck("w3_ack");

    // Asynchronous reset in the middle of a burst read.
    clearLogs();
    stallCycles = 5;
    applyStimulus(8'h0F); applyStimulus(8'h20); applyStimulus(8'h01);
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) break;
      @(negedge clk);
    end
    checkOutput("rst_txv", 32'(tx_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_outs",
                   {11'd0, busy, tx_valid, bus_wr, bus_rd, bus_addr, tx_data},
                   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stallCycles = 0;
    @(negedge clk);
    clearLogs();
    applyStimulus(8'h00); applyStimulus(8'h20); applyStimulus(8'h09);
    waitIdle("r3_idle");
    checkOutput("r3_txn", 32'(txQ.size()), 32'd2);
    checkOutput("r3_tx0", 32'(txQ[0]), 32'h56);
    checkOutput("r3_tx1", 32'(txQ[1]), 32'h78);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
